alu_sched: RTL and testbench

- Two-requester scheduler that shares the single 8-bit combinational ALU.
- Arbitrates between requesters and latches the winner's operands and opcode.
- Drives the ALU select code, captures dout/carry, and returns a tagged response.
- Adds one sequenced operation, MUL (low byte via repeated ADD), built on the same ALU. Sits between the decode/execute front ends and the ALU instance.

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu_sched_arb.sv | 55 +++++
 rtl/alu_sched.sv | 170 +++++++++++++++++
 tb/tb_alu_sched.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, ALU select and FSM encodings for the ALU scheduler
package alu_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_AND   = 3'd1,
    OP_PASSA = 3'd2,
    OP_PASSB = 3'd3,
    OP_SUB   = 3'd4,
    OP_INC   = 3'd5,
    OP_MUL   = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_AND   = 5'b00001;
  localparam logic [4:0] ALU_PASSA = 5'b00010;
  localparam logic [4:0] ALU_PASSB = 5'b00011;
  localparam logic [4:0] ALU_SUB   = 5'b01100;
  localparam logic [4:0] ALU_INC   = 5'b10100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // MUL is built from ADD steps; the reserved opcode just parks the ALU on PASSA
  function automatic logic [4:0] op_to_sel(input op_e op);
    logic [4:0] sel;
    case (op)
      OP_ADD:   sel = ALU_ADD;
      OP_AND:   sel = ALU_AND;
      OP_PASSA: sel = ALU_PASSA;
      OP_PASSB: sel = ALU_PASSB;
      OP_SUB:   sel = ALU_SUB;
      OP_INC:   sel = ALU_INC;
      OP_MUL:   sel = ALU_ADD;
      default:  sel = ALU_PASSA;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_sched_arb.sv
// rtl/alu_sched_arb.sv - 2-way request arbiter, round-robin or fixed priority under ALU_SCHED_FIXED_PRIO_EN
module alu_sched_arb
  import alu_pkg::*;
(
`ifndef ALU_SCHED_FIXED_PRIO_EN
  input  logic       clk,
  input  logic       rst_n,
`endif
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] grant
);

`ifdef ALU_SCHED_FIXED_PRIO_EN

  // requester 0 wins whenever it asks; requester 1 only gets an idle slot
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (valid[0]) begin
        grant = 2'b01;
      end else if (valid[1]) begin
        grant = 2'b10;
      end
    end
  end

`else

  logic last;

  // on a tie the requester that was not granted last wins; a lone requester always wins
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (valid == 2'b11) begin
        grant = last ? 2'b01 : 2'b10;
      end else begin
        grant = valid;
      end
    end
  end

  // remember who was granted; reset to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (|grant) begin
      last <= grant[1];
    end
  end

`endif

endmodule

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - two-requester scheduler for the shared ALU with sequenced MUL (ALU_SCHED_FIXED_PRIO_EN selects fixed priority)
module alu_sched #(
  parameter int DATA_W  = alu_pkg::DATA_W,
  parameter int MUL_MAX = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2:0]        req_op0,
  input  logic [2:0]        req_op1,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_b1,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_dout,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output logic              rsp_err
);

  import alu_pkg::*;

  localparam logic [DATA_W-1:0] MUL_MAX_V = DATA_W'(MUL_MAX);
  localparam logic [DATA_W-1:0] ONE       = DATA_W'(1);

  state_e            state;
  state_e            state_d;
  op_e               op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] cnt;
  logic              sticky;
  logic [DATA_W-1:0] mul_n;
  logic [1:0]        grant;
  logic              arb_en;

  // arbitration is only open while idle and out of reset, so grant doubles as req_ready
  assign arb_en = rst_n && (state == ST_IDLE);

  // effective MUL iteration count after clamping b
  assign mul_n = (b_q > MUL_MAX_V) ? MUL_MAX_V : b_q;

  alu_sched_arb u_arb (
`ifndef ALU_SCHED_FIXED_PRIO_EN
    .clk   (clk),
    .rst_n (rst_n),
`endif
    .valid (req_valid),
    .en    (arb_en),
    .grant (grant)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // next state plus the ALU drive and handshake outputs
  always_comb begin
    state_d   = state;
    alu_a     = '0;
    alu_b     = '0;
    alu_sel   = ALU_PASSA;
    rsp_valid = 1'b0;
    req_ready = grant;
    case (state)
      ST_IDLE: begin
        if (|grant) begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_a   = a_q;
        alu_b   = b_q;
        alu_sel = op_to_sel(op_q);
        if ((op_q == OP_MUL) && (mul_n != '0)) begin
          state_d = ST_MUL;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_MUL: begin
        alu_a   = acc;
        alu_b   = a_q;
        alu_sel = ALU_ADD;
        if (cnt == ONE) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // operand latch, MUL accumulator and the response registers held through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      cnt       <= '0;
      sticky    <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            op_q   <= op_e'(grant[1] ? req_op1 : req_op0);
            a_q    <= grant[1] ? req_a1 : req_a0;
            b_q    <= grant[1] ? req_b1 : req_b0;
            rsp_id <= grant[1];
          end
        end
        ST_EXEC: begin
          rsp_err <= 1'b0;
          if (op_q == OP_RSVD) begin
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b1;
          end else if (op_q == OP_MUL) begin
            acc       <= '0;
            cnt       <= mul_n;
            sticky    <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
          end else begin
            rsp_data  <= alu_dout;
            rsp_carry <= alu_carry;
          end
        end
        ST_MUL: begin
          acc    <= alu_dout;
          sticky <= sticky | alu_carry;
          cnt    <= cnt - ONE;
          if (cnt == ONE) begin
            rsp_data  <= alu_dout;
            rsp_carry <= sticky | alu_carry;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - self-checking bench for alu_sched with behavioural ALU and response model
module tb_alu_sched;

  localparam int DW      = 8;
  localparam int MUL_MAX = 255;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [2:0]    req_op0   = 3'd0;
  logic [2:0]    req_op1   = 3'd0;
  logic [DW-1:0] req_a0    = '0;
  logic [DW-1:0] req_a1    = '0;
  logic [DW-1:0] req_b0    = '0;
  logic [DW-1:0] req_b1    = '0;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [4:0]    alu_sel;
  logic [DW-1:0] alu_dout;
  logic          alu_carry;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_id;
  logic [DW-1:0] rsp_data;
  logic          rsp_carry;
  logic          rsp_err;
  logic [DW:0]   alu_r;

  typedef struct {
    int id; int op; int a; int b;
    int edata; int ecarry; int eerr; int elat;
  } vec_t;

  vec_t vec[$];

  int checks = 0;
  int fails  = 0;
  int tmo_cnt = 0;
  int tmo_seen = 0;

  always #5 clk = ~clk;

  alu_sched #(.DATA_W(DW), .MUL_MAX(MUL_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op0   (req_op0),
    .req_op1   (req_op1),
    .req_a0    (req_a0),
    .req_a1    (req_a1),
    .req_b0    (req_b0),
    .req_b1    (req_b1),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_dout  (alu_dout),
    .alu_carry (alu_carry),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .rsp_err   (rsp_err)
  );

  // stand-in for the shared combinational ALU
  always_comb begin
    alu_r = '0;
    case (alu_sel)
      5'b00000: alu_r = {1'b0, alu_a} + {1'b0, alu_b};
      5'b00001: alu_r = {1'b0, alu_a & alu_b};
      5'b00010: alu_r = {1'b0, alu_a};
      5'b00011: alu_r = {1'b0, alu_b};
      5'b01100: alu_r = {1'b0, alu_a} - {1'b0, alu_b};
      5'b10100: alu_r = {1'b0, alu_a} + 9'd1;
      default:  alu_r = '0;
    endcase
    alu_dout  = alu_r[DW-1:0];
    alu_carry = alu_r[DW];
  end

  // ---------------- model and compare ----------------
  int cyc = 0;
  bit m_busy = 0;
  int m_last = 1;
  int m_acc, m_due, m_id, m_data, m_carry, m_err;
  int resp_num = 0;
  bit first_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // arithmetic meaning of each opcode; carry is any excursion outside 0..255
  task automatic model_op(input int op, input int a, input int b,
                          output int d, output int c, output int e, output int lat);
    int p, n;
    p = 0; e = 0; lat = 2;
    case (op)
      0: p = a + b;
      1: p = a & b;
      2: p = a;
      3: p = b;
      4: p = a - b;
      5: p = a + 1;
      6: begin
        n = (b > MUL_MAX) ? MUL_MAX : b;
        p = a * n;
        if (n > 0) lat = 2 + n;
      end
      default: e = 1;
    endcase
    d = p & 255;
    c = ((p < 0) || (p > 255)) ? 1 : 0;
  endtask

  always @(negedge clk) begin
    logic [1:0] exp_ready;
    bit exp_valid;
    int w, op, a, b, lat;
    cyc++;
    if (tmo_cnt != tmo_seen) begin
      checks++;
      fails++;
      $display("FAIL timeout: %0d wait(s) expired, expected 0", tmo_cnt - tmo_seen);
      tmo_seen = tmo_cnt;
    end
    if (!rst_n) begin
      m_busy = 0;
      m_last = 1;
      first_seen = 0;
      chk("reset_req_ready", req_ready, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_data", rsp_data, 0);
      chk("reset_rsp_carry", rsp_carry, 0);
      chk("reset_rsp_err", rsp_err, 0);
      chk("reset_rsp_id", rsp_id, 0);
    end else begin
      exp_ready = 2'b00;
      if (!m_busy) begin
        if (req_valid == 2'b11) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
          exp_ready = 2'b01;
`else
          exp_ready = (m_last == 0) ? 2'b10 : 2'b01;
`endif
        end else begin
          exp_ready = req_valid;
        end
      end
      chk("req_ready", req_ready, exp_ready);
      exp_valid = m_busy && (cyc >= m_due);
      chk("rsp_valid", rsp_valid, exp_valid);
      if (exp_valid && rsp_valid) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_carry", rsp_carry, m_carry);
        chk("rsp_err", rsp_err, m_err);
        if (resp_num < vec.size()) begin
          chk("vec_id", rsp_id, vec[resp_num].id);
          chk("vec_data", rsp_data, vec[resp_num].edata);
          chk("vec_carry", rsp_carry, vec[resp_num].ecarry);
          chk("vec_err", rsp_err, vec[resp_num].eerr);
          if (!first_seen) chk("vec_latency", cyc - m_acc, vec[resp_num].elat);
        end else begin
          checks++;
          fails++;
          $display("FAIL extra_response: got response %0d expected at most %0d", resp_num, vec.size());
        end
        first_seen = 1;
      end
      if (exp_valid && rsp_ready) begin
        m_busy = 0;
        first_seen = 0;
        resp_num++;
      end
      if ((exp_ready & req_valid) != 2'b00) begin
        w  = exp_ready[1] ? 1 : 0;
        op = w ? int'(req_op1) : int'(req_op0);
        a  = w ? int'(req_a1) : int'(req_a0);
        b  = w ? int'(req_b1) : int'(req_b0);
        model_op(op, a, b, m_data, m_carry, m_err, lat);
        m_id   = w;
        m_last = w;
        m_acc  = cyc;
        m_due  = cyc + lat;
        m_busy = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic add_vec(input int id, input int op, input int a, input int b,
                         input int d, input int c, input int e, input int l);
    vec_t v;
    v.id = id; v.op = op; v.a = a; v.b = b;
    v.edata = d; v.ecarry = c; v.eerr = e; v.elat = l;
    vec.push_back(v);
  endtask

  task automatic drive(input int id, input int op, input int a, input int b);
    if (id == 0) begin
      req_op0 = 3'(op); req_a0 = DW'(a); req_b0 = DW'(b); req_valid[0] = 1'b1;
    end else begin
      req_op1 = 3'(op); req_a1 = DW'(a); req_b1 = DW'(b); req_valid[1] = 1'b1;
    end
  endtask

  task automatic wait_accept(input int id);
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_valid[id] && req_ready[id]) begin ok = 1; break; end
    end
    if (!ok) tmo_cnt++;
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_retire();
    bit ok;
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin ok = 1; break; end
    end
    if (!ok) tmo_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts;
    // tie phase: response order is the grant order
`ifdef ALU_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) add_vec(0, 0, 8'h01, 8'h02, 8'h03, 0, 0, 2);
`else
    for (int i = 0; i < 2; i++) begin
      add_vec(0, 0, 8'h01, 8'h02, 8'h03, 0, 0, 2);
      add_vec(1, 0, 8'h80, 8'h80, 8'h00, 1, 0, 2);
    end
`endif
    add_vec(0, 0, 8'hF0, 8'h20, 8'h10, 1, 0, 2);    // 4 ADD wrap
    add_vec(1, 4, 8'h05, 8'h07, 8'hFE, 1, 0, 2);    // 5 SUB borrow
    add_vec(0, 5, 8'hFF, 8'h00, 8'h00, 1, 0, 2);    // 6 INC wrap
    add_vec(1, 1, 8'hF0, 8'h3C, 8'h30, 0, 0, 2);    // 7 AND
    add_vec(0, 2, 8'hA5, 8'h11, 8'hA5, 0, 0, 2);    // 8 PASSA
    add_vec(1, 3, 8'hA5, 8'h11, 8'h11, 0, 0, 2);    // 9 PASSB
    add_vec(0, 6, 8'h13, 8'h0E, 8'h0A, 1, 0, 16);   // 10 MUL 19*14=0x10A
    add_vec(0, 6, 8'h07, 8'h00, 8'h00, 0, 0, 2);    // 11 MUL by zero
    add_vec(1, 6, 8'h03, 8'h05, 8'h0F, 0, 0, 7);    // 12 MUL no overflow
    add_vec(0, 6, 8'h02, 8'hFF, 8'hFE, 1, 0, 257);  // 13 MUL at MUL_MAX
    add_vec(1, 7, 8'h05, 8'h09, 8'h00, 0, 1, 2);    // 14 reserved opcode
    add_vec(0, 0, 8'h11, 8'h22, 8'h33, 0, 0, 2);    // 15 held by back-pressure
    add_vec(1, 2, 8'h44, 8'h00, 8'h44, 0, 0, 2);    // 16 waits behind it
    add_vec(0, 0, 8'h01, 8'h02, 8'h03, 0, 0, 2);    // 17 first tie after reset
    add_vec(1, 0, 8'h80, 8'h80, 8'h00, 1, 0, 2);    // 18 then the loser

    repeat (3) @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // both requesters valid continuously
    drive(0, 0, 8'h01, 8'h02);
    drive(1, 0, 8'h80, 8'h80);
    accepts = 0;
    for (int i = 0; i < 100 && accepts < 4; i++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != 2'b00) accepts++;
    end
    if (accepts < 4) tmo_cnt++;
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_retire();

    // single requester directed vectors
    for (int k = 4; k <= 14; k++) begin
      drive(vec[k].id, vec[k].op, vec[k].a, vec[k].b);
      wait_accept(vec[k].id);
      wait_retire();
    end

    // response back-pressure with the other requester waiting
    drive(0, 0, 8'h11, 8'h22);
    wait_accept(0);
    drive(1, 2, 8'h44, 8'h00);
    rsp_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_accept(1);
    wait_retire();

    // reset in the middle of a MUL (cnt=6), then a tie
    drive(0, 6, 8'h03, 8'h0A);
    wait_accept(0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    drive(0, 0, 8'h01, 8'h02);
    drive(1, 0, 8'h80, 8'h80);
    repeat (2) @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    wait_accept(0);
    wait_accept(1);
    wait_retire();

    repeat (3) @(negedge clk);
    #1;
    if (resp_num != vec.size()) begin
      $display("FAIL response_count: got %0d expected %0d", resp_num, vec.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails + ((resp_num != vec.size()) ? 1 : 0));
    $finish;
  end

endmodule
